// File: rtl/alu_md_decoder_seq.sv
// EX-stage ALU control decoder with an iterative MULT/DIV sequencer and HI/LO registers.
// Decode is combinational; MULT/MULTU/DIV/DIVU take DATA_WIDTH cycles in MUL/DIV, stalling the pipe.
// Optional feature macro: ALU_DEC_MTHILO_EN (adds MTHI/MTLO writes into HI/LO).
module alu_md_decoder_seq #(
    parameter int unsigned CODE_WIDTH     = 6,
    parameter int unsigned ALU_OP_WIDTH   = 2,
    parameter int unsigned ALU_CTRL_WIDTH = 3,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      flush,
    input  logic [ALU_OP_WIDTH-1:0]   alu_op,
    input  logic [CODE_WIDTH-1:0]     func,
    input  logic [DATA_WIDTH-1:0]     src_a,
    input  logic [DATA_WIDTH-1:0]     src_b,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic                      hilo_sel,
    output logic                      md_stall,
    output logic                      md_done,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo
);

    localparam int unsigned W         = DATA_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_RTYP = ALU_OP_WIDTH'(2);

    localparam logic [CODE_WIDTH-1:0] F_ADD   = CODE_WIDTH'(6'b100000);
    localparam logic [CODE_WIDTH-1:0] F_SUB   = CODE_WIDTH'(6'b100010);
    localparam logic [CODE_WIDTH-1:0] F_SLT   = CODE_WIDTH'(6'b101010);
    localparam logic [CODE_WIDTH-1:0] F_MUL   = CODE_WIDTH'(6'b011100);
    localparam logic [CODE_WIDTH-1:0] F_AND   = CODE_WIDTH'(6'b100100);
    localparam logic [CODE_WIDTH-1:0] F_OR    = CODE_WIDTH'(6'b100101);
    localparam logic [CODE_WIDTH-1:0] F_MFHI  = CODE_WIDTH'(6'b010000);
    localparam logic [CODE_WIDTH-1:0] F_MFLO  = CODE_WIDTH'(6'b010010);
    localparam logic [CODE_WIDTH-1:0] F_MULT  = CODE_WIDTH'(6'b011000);
    localparam logic [CODE_WIDTH-1:0] F_MULTU = CODE_WIDTH'(6'b011001);
    localparam logic [CODE_WIDTH-1:0] F_DIV   = CODE_WIDTH'(6'b011010);
    localparam logic [CODE_WIDTH-1:0] F_DIVU  = CODE_WIDTH'(6'b011011);
`ifdef ALU_DEC_MTHILO_EN
    localparam logic [CODE_WIDTH-1:0] F_MTHI  = CODE_WIDTH'(6'b010001);
    localparam logic [CODE_WIDTH-1:0] F_MTLO  = CODE_WIDTH'(6'b010011);
`endif

    localparam logic [ALU_CTRL_WIDTH-1:0] C_AND  = ALU_CTRL_WIDTH'(3'b000);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_OR   = ALU_CTRL_WIDTH'(3'b001);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_ADD  = ALU_CTRL_WIDTH'(3'b010);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_HILO = ALU_CTRL_WIDTH'(3'b011);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_SUB  = ALU_CTRL_WIDTH'(3'b100);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_MUL  = ALU_CTRL_WIDTH'(3'b101);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_SLT  = ALU_CTRL_WIDTH'(3'b110);
    localparam logic [ALU_CTRL_WIDTH-1:0] C_NONE = ALU_CTRL_WIDTH'(3'b111);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t state, state_d;

    logic                 is_rtype, is_md, is_div, is_signed, start, last_step;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]         opb;        // multiplicand (MUL) or divisor (DIV), magnitude
    logic [2*W-1:0]       prod;       // {partial upper, remaining multiplier bits}
    logic [W:0]           rem;        // one guard bit so the trial subtract sign is visible
    logic [W-1:0]         quo;        // dividend bits shift out, quotient bits shift in
    logic                 neg_q, neg_r, b_zero;

    logic                 a_neg, b_neg;
    logic [W-1:0]         abs_a, abs_b;
    logic [W:0]           mul_sum, rem_sh, diff;
    logic [2*W-1:0]       prod_nxt, mul_res;
    logic [W:0]           rem_nxt;
    logic [W-1:0]         quo_nxt, div_q, div_r;
`ifdef ALU_DEC_MTHILO_EN
    logic                 is_mthi, is_mtlo, mt_ok;
`endif

    // ALU select decode from alu_op/func
    always_comb begin
        alu_control = C_NONE;
        hilo_sel    = 1'b0;
        case (alu_op)
            OP_ADD:  alu_control = C_ADD;
            OP_SUB:  alu_control = C_SUB;
            OP_RTYP: begin
                case (func)
                    F_ADD:   alu_control = C_ADD;
                    F_SUB:   alu_control = C_SUB;
                    F_SLT:   alu_control = C_SLT;
                    F_MUL:   alu_control = C_MUL;
                    F_AND:   alu_control = C_AND;
                    F_OR:    alu_control = C_OR;
                    F_MFHI:  begin
                        alu_control = C_HILO;
                        hilo_sel    = 1'b1;
                    end
                    F_MFLO:  alu_control = C_HILO;
                    default: alu_control = C_NONE;
                endcase
            end
            default: alu_control = C_NONE;
        endcase
    end

    // Sequencer request qualification and operand magnitudes
    always_comb begin
        is_rtype  = (alu_op == OP_RTYP);
        is_md     = is_rtype && (func == F_MULT || func == F_MULTU ||
                                 func == F_DIV  || func == F_DIVU);
        is_div    = (func == F_DIV) || (func == F_DIVU);
        is_signed = (func == F_MULT) || (func == F_DIV);
        start     = valid_in && !flush && !rst && is_md && (state == StIdle);
        a_neg     = is_signed && src_a[W-1];
        b_neg     = is_signed && src_b[W-1];
        abs_a     = a_neg ? -src_a : src_a;
        abs_b     = b_neg ? -src_b : src_b;
        md_stall  = start || (state == StMul) || (state == StDiv);
        md_done   = (state == StDone);
        last_step = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
    end

`ifdef ALU_DEC_MTHILO_EN
    // MTHI/MTLO only act from IDLE; while busy the instruction is held by the stall
    always_comb begin
        is_mthi = is_rtype && (func == F_MTHI);
        is_mtlo = is_rtype && (func == F_MTLO);
        mt_ok   = valid_in && !flush && (state == StIdle);
    end
`endif

    // One shift-add step and one restoring-divide step, plus sign fix-up of the final values
    always_comb begin
        mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opb} : '0);
        prod_nxt = {mul_sum, prod[W-1:1]};
        rem_sh   = {rem[W-1:0], quo[W-1]};
        diff     = rem_sh - {1'b0, opb};
        if (!diff[W]) begin
            rem_nxt = diff;
            quo_nxt = {quo[W-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh;
            quo_nxt = {quo[W-2:0], 1'b0};
        end
        mul_res = neg_q ? -prod_nxt : prod_nxt;
        // Divide by zero leaves quotient all ones and remainder = |dividend|; only HI's sign is restored
        div_q   = (neg_q && !b_zero) ? -quo_nxt : quo_nxt;
        div_r   = neg_r ? -rem_nxt[W-1:0] : rem_nxt[W-1:0];
    end

    // FSM next state
    always_comb begin
        state_d = state;
        case (state)
            StIdle: if (start) state_d = is_div ? StDiv : StMul;
            StMul, StDiv: begin
                if (flush)          state_d = StIdle;
                else if (last_step) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= StIdle;
        else     state <= state_d;
    end

    // Sequencer datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            opb   <= '0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            b_zero <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (start) begin
                cnt    <= '0;
                opb    <= is_div ? abs_b : abs_a;
                prod   <= {{W{1'b0}}, abs_b};
                rem    <= '0;
                quo    <= abs_a;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (src_b == '0);
            end else if (state == StMul && !flush) begin
                cnt  <= cnt + CNT_WIDTH'(1);
                prod <= prod_nxt;
                if (last_step) begin
                    hi <= mul_res[2*W-1:W];
                    lo <= mul_res[W-1:0];
                end
            end else if (state == StDiv && !flush) begin
                cnt <= cnt + CNT_WIDTH'(1);
                rem <= rem_nxt;
                quo <= quo_nxt;
                if (last_step) begin
                    hi <= div_r;
                    lo <= div_q;
                end
            end
`ifdef ALU_DEC_MTHILO_EN
            if (mt_ok && is_mthi) hi <= src_a;
            if (mt_ok && is_mtlo) lo <= src_a;
`endif
        end
    end

endmodule

// File: tb/tb_alu_md_decoder_seq.sv
// Self-checking bench for alu_md_decoder_seq: decode sweep, directed and random MULT/DIV,
// flush/reset abort, and MTHI/MTLO behaviour with or without ALU_DEC_MTHILO_EN.
module tb_alu_md_decoder_seq;

    logic        clk = 1'b0;
    logic        rst, valid_in, flush;
    logic [1:0]  alu_op;
    logic [5:0]  func;
    logic [31:0] src_a, src_b;
    logic [2:0]  alu_control;
    logic        hilo_sel, md_stall, md_done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    alu_md_decoder_seq dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .flush       (flush),
        .alu_op      (alu_op),
        .func        (func),
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (alu_control),
        .hilo_sel    (hilo_sel),
        .md_stall    (md_stall),
        .md_done     (md_done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {hilo_sel, alu_control}
    function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 4'b0010;
        if (op == 2'd1) return 4'b0100;
        if (op == 2'd3) return 4'b0111;
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0100;
            6'h2A:   return 4'b0110;
            6'h1C:   return 4'b0101;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h10:   return 4'b1011;
            6'h12:   return 4'b0011;
            default: return 4'b0111;
        endcase
    endfunction

    // Arithmetic reference for HI/LO after a MULT/DIV
    function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = '0;
        l  = '0;
        case (f)
            6'h18: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            6'h19: begin
                p = {32'b0, a} * {32'b0, b};
                h = p[63:32];
                l = p[31:0];
            end
            6'h1A: begin
                if (b == 0) begin
                    h = a;
                    l = '1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = 32'(q);
                    h = 32'(r);
                end
            end
            default: begin
                if (b == 0) begin
                    h = a;
                    l = '1;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el;
        int          stall;
        bit          seen;
        ref_md(f, a, b, eh, el);
        @(posedge clk) #1;
        valid_in = 1'b1;
        alu_op   = 2'd2;
        func     = f;
        src_a    = a;
        src_b    = b;
        stall    = 0;
        seen     = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (md_stall) stall++;
            if (md_done)  seen = 1'b1;
        end
        check({tag, ".done"}, 64'(seen), 64'd1);
        check({tag, ".stall"}, 64'(stall), 64'd33);
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lo"}, 64'(lo), 64'(el));
        @(posedge clk) #1;
        valid_in = 1'b0;
        @(negedge clk);
        check({tag, ".pulse"}, 64'({md_done, md_stall}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b, exp_hi, exp_lo;
        bit          seen;

        rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
        alu_op = 2'd2; func = 6'h25; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.hi", 64'(hi), 64'd0);
        check("rst.lo", 64'(lo), 64'd0);
        check("rst.stall", 64'(md_stall), 64'd0);
        check("rst.done", 64'(md_done), 64'd0);
        check("or.ctrl", 64'(alu_control), 64'd1);
        @(posedge clk) #1;
        rst = 1'b0;

        // Full decode sweep with no live instruction
        for (int op = 0; op < 4; op++) begin
            for (int fc = 0; fc < 64; fc++) begin
                @(posedge clk) #1;
                alu_op = 2'(op);
                func   = 6'(fc);
                @(negedge clk);
                check($sformatf("dec.%0d.%02h", op, fc), 64'({hilo_sel, alu_control}),
                      64'(ref_dec(2'(op), 6'(fc))));
            end
        end

        run_md("multu_max", 6'h19, 32'hFFFF_FFFF, 32'h2);
        run_md("mult_neg", 6'h18, -32'sd7, 32'd3);
        run_md("div_neg", 6'h1A, -32'sd7, 32'd2);
        run_md("divu_zero", 6'h1B, 32'd100, 32'd0);
        run_md("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("div_zero_s", 6'h1A, -32'sd9, 32'd0);

        for (int n = 0; n < 20; n++) begin
            f = 6'(6'h18 + $urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 40);
                b = $urandom_range(0, 9);
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            if ($urandom_range(0, 7) == 0) b = '0;
            run_md($sformatf("rnd%0d", n), f, a, b);
        end

        // Flush mid-multiply: HI/LO keep prior values, no done pulse
        run_md("pre_flush", 6'h1B, 32'd5, 32'd0);
        @(posedge clk) #1;
        valid_in = 1'b1; alu_op = 2'd2; func = 6'h18; src_a = 32'd7; src_b = 32'd9;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk) #1;
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("flush.stall", 64'(md_stall), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
        end
        check("flush.nodone", 64'(seen), 64'd0);
        check("flush.hi", 64'(hi), 64'd5);
        check("flush.lo", 64'(lo), 64'hFFFF_FFFF);

        // MTHI / MTLO
        exp_hi = 32'd5;
        exp_lo = 32'hFFFF_FFFF;
`ifdef ALU_DEC_MTHILO_EN
        exp_hi = 32'h1234;
        exp_lo = 32'hABCD;
`endif
        @(posedge clk) #1;
        valid_in = 1'b1; alu_op = 2'd2; func = 6'h11; src_a = 32'h1234;
        @(negedge clk);
        check("mthi.ctrl", 64'(alu_control), 64'd7);
        check("mthi.stall", 64'(md_stall), 64'd0);
        @(posedge clk) #1;
        func = 6'h13; src_a = 32'hABCD;
        @(negedge clk);
        check("mthi.hi", 64'(hi), 64'(exp_hi));
        check("mthi.done", 64'(md_done), 64'd0);
        @(posedge clk) #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("mtlo.lo", 64'(lo), 64'(exp_lo));

        // Reset mid-divide clears HI/LO and aborts
        @(posedge clk) #1;
        valid_in = 1'b1; alu_op = 2'd2; func = 6'h1B; src_a = 32'd77; src_b = 32'd3;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("rstbusy.stall", 64'(md_stall), 64'd0);
        check("rstbusy.hi", 64'(hi), 64'd0);
        check("rstbusy.lo", 64'(lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
